// File: rtl/hazard_unit.sv
// hazard_unit: pipeline hazard controller (load-use stall, multi-cycle EX freeze,
// taken-branch flush) with saturating stall/flush event counters.
`default_nettype none

module hazard_unit #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       ID_rs1,
    input  logic [4:0]       ID_rs2,
    input  logic             ID_valid,
    input  logic             EX_MemRead,
    input  logic [4:0]       EX_rd,
    input  logic             EX_branch_taken,
    input  logic             EX_busy,
    output logic             PCWrite,
    output logic             IF_ID_Write,
    output logic             ID_EX_Write,
    output logic             ID_EX_Bubble,
    output logic             IF_ID_Flush,
    output logic             ID_EX_Flush,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    localparam logic [2:0] S_INIT       = 3'd0;
    localparam logic [2:0] S_RUN        = 3'd1;
    localparam logic [2:0] S_LOAD_STALL = 3'd2;
    localparam logic [2:0] S_BUSY       = 3'd3;
    localparam logic [2:0] S_FLUSH      = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] stall_count_q, stall_count_d;
    logic [CNT_W-1:0] flush_count_q, flush_count_d;

    logic load_use;
    logic in_init;
    logic branch_ev;
    logic busy_ev;
    logic lu_ev;

    assign load_use = ID_valid & EX_MemRead & (EX_rd != 5'd0) &
                      ((EX_rd == ID_rs1) | (EX_rd == ID_rs2));

    // Event resolution in priority order; the bubble just inserted masks load_use once.
    assign in_init   = (state_q == S_INIT);
    assign branch_ev = ~in_init & EX_branch_taken;
    assign busy_ev   = ~in_init & ~EX_branch_taken & EX_busy;
    assign lu_ev     = ~in_init & ~EX_branch_taken & ~EX_busy &
                       load_use & (state_q != S_LOAD_STALL);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= S_INIT;
            stall_count_q <= '0;
            flush_count_q <= '0;
        end else begin
            state_q       <= state_d;
            stall_count_q <= stall_count_d;
            flush_count_q <= flush_count_d;
        end
    end

    always_comb begin
        state_d = S_RUN;
        case (state_q)
            S_INIT: state_d = S_RUN;
            default: begin
                if (branch_ev)    state_d = S_FLUSH;
                else if (busy_ev) state_d = S_BUSY;
                else if (lu_ev)   state_d = S_LOAD_STALL;
                else              state_d = S_RUN;
            end
        endcase
    end

    always_comb begin
        stall_count_d = stall_count_q;
        flush_count_d = flush_count_q;
        if ((busy_ev | lu_ev) && (stall_count_q != '1))
            stall_count_d = stall_count_q + CNT_W'(1);
        if (branch_ev && (flush_count_q != '1))
            flush_count_d = flush_count_q + CNT_W'(1);
    end

    always_comb begin
        PCWrite      = 1'b1;
        IF_ID_Write  = 1'b1;
        ID_EX_Write  = 1'b1;
        ID_EX_Bubble = 1'b0;
        IF_ID_Flush  = 1'b0;
        ID_EX_Flush  = 1'b0;
        if (in_init) begin
            PCWrite      = 1'b0;
            IF_ID_Write  = 1'b0;
            ID_EX_Bubble = 1'b1;
        end else if (branch_ev) begin
            IF_ID_Flush  = 1'b1;
            ID_EX_Flush  = 1'b1;
        end else if (busy_ev) begin
            PCWrite      = 1'b0;
            IF_ID_Write  = 1'b0;
            ID_EX_Write  = 1'b0;
        end else if (lu_ev) begin
            PCWrite      = 1'b0;
            IF_ID_Write  = 1'b0;
            ID_EX_Bubble = 1'b1;
        end
    end

    assign stall_count = stall_count_q;
    assign flush_count = flush_count_q;

endmodule

`default_nettype wire

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: directed vectors with a queue-based scoreboard for hazard_unit.
`default_nettype none

module tb_hazard_unit;

    localparam int CW = 4;

    localparam logic [5:0] O_INIT = 6'b001100;
    localparam logic [5:0] O_RUN  = 6'b111000;
    localparam logic [5:0] O_BR   = 6'b111011;
    localparam logic [5:0] O_BUSY = 6'b000000;
    localparam logic [5:0] O_LU   = 6'b001100;

    typedef struct packed {
        logic [5:0]    o;
        logic [CW-1:0] s;
        logic [CW-1:0] f;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [4:0]    ID_rs1 = '0, ID_rs2 = '0, EX_rd = '0;
    logic          ID_valid = 1'b0, EX_MemRead = 1'b0;
    logic          EX_branch_taken = 1'b0, EX_busy = 1'b0;
    logic          PCWrite, IF_ID_Write, ID_EX_Write, ID_EX_Bubble, IF_ID_Flush, ID_EX_Flush;
    logic [CW-1:0] stall_count, flush_count;

    exp_t q[$];
    exp_t e;
    int   n_checks = 0;
    int   n_fail   = 0;
    logic [5:0] outs;

    hazard_unit #(.CNT_W(CW)) dut (
        .clk             (clk),
        .reset           (reset),
        .ID_rs1          (ID_rs1),
        .ID_rs2          (ID_rs2),
        .ID_valid        (ID_valid),
        .EX_MemRead      (EX_MemRead),
        .EX_rd           (EX_rd),
        .EX_branch_taken (EX_branch_taken),
        .EX_busy         (EX_busy),
        .PCWrite         (PCWrite),
        .IF_ID_Write     (IF_ID_Write),
        .ID_EX_Write     (ID_EX_Write),
        .ID_EX_Bubble    (ID_EX_Bubble),
        .IF_ID_Flush     (IF_ID_Flush),
        .ID_EX_Flush     (ID_EX_Flush),
        .stall_count     (stall_count),
        .flush_count     (flush_count)
    );

    always #5 clk = ~clk;

    assign outs = {PCWrite, IF_ID_Write, ID_EX_Write, ID_EX_Bubble, IF_ID_Flush, ID_EX_Flush};

    // One vector per cycle: drive just after the edge, expectation queued for the monitor.
    task automatic vec(input logic rst, input logic v, input logic mr, input logic [4:0] rd,
                       input logic [4:0] r1, input logic [4:0] r2, input logic br,
                       input logic bz, input logic [5:0] o, input int s, input int f);
        exp_t x;
        @(posedge clk);
        #1;
        reset = rst; ID_valid = v; EX_MemRead = mr; EX_rd = rd;
        ID_rs1 = r1; ID_rs2 = r2; EX_branch_taken = br; EX_busy = bz;
        x.o = o; x.s = CW'(s); x.f = CW'(f);
        q.push_back(x);
    endtask

    always @(negedge clk) begin
        if (q.size() != 0) begin
            e = q.pop_front();
            n_checks++;
            if (outs !== e.o) begin
                n_fail++;
                $display("FAIL outputs t=%0t got=%b exp=%b", $time, outs, e.o);
            end
            n_checks++;
            if (stall_count !== e.s) begin
                n_fail++;
                $display("FAIL stall_count t=%0t got=%0d exp=%0d", $time, stall_count, e.s);
            end
            n_checks++;
            if (flush_count !== e.f) begin
                n_fail++;
                $display("FAIL flush_count t=%0t got=%0d exp=%0d", $time, flush_count, e.f);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        // reset state, then release: one more INIT cycle before RUN
        vec(0, 0,0,5'd0,5'd0,5'd0, 0,0, O_INIT, 0, 0);
        vec(0, 0,0,5'd0,5'd0,5'd0, 0,0, O_INIT, 0, 0);
        vec(1, 0,0,5'd0,5'd0,5'd0, 0,0, O_INIT, 0, 0);
        vec(1, 0,0,5'd0,5'd0,5'd0, 0,0, O_RUN,  0, 0);
        vec(1, 0,0,5'd0,5'd0,5'd0, 0,0, O_RUN,  0, 0);
        // load-use on rs2 held two cycles: single stall
        vec(1, 1,1,5'd5,5'd0,5'd5, 0,0, O_LU,   0, 0);
        vec(1, 1,1,5'd5,5'd0,5'd5, 0,0, O_RUN,  1, 0);
        vec(1, 0,0,5'd0,5'd0,5'd0, 0,0, O_RUN,  1, 0);
        // EX_rd = 0, ID_valid = 0, MemRead = 0: no stall
        vec(1, 1,1,5'd0,5'd0,5'd0, 0,0, O_RUN,  1, 0);
        vec(1, 1,1,5'd0,5'd0,5'd0, 0,0, O_RUN,  1, 0);
        vec(1, 0,1,5'd5,5'd5,5'd0, 0,0, O_RUN,  1, 0);
        vec(1, 1,0,5'd7,5'd7,5'd0, 0,0, O_RUN,  1, 0);
        // load-use on rs1
        vec(1, 1,1,5'd7,5'd7,5'd3, 0,0, O_LU,   1, 0);
        vec(1, 0,0,5'd0,5'd0,5'd0, 0,0, O_RUN,  2, 0);
        // reset clears counters immediately
        vec(0, 0,0,5'd0,5'd0,5'd0, 0,0, O_INIT, 0, 0);
        vec(1, 0,0,5'd0,5'd0,5'd0, 0,0, O_INIT, 0, 0);
        vec(1, 0,0,5'd0,5'd0,5'd0, 0,0, O_RUN,  0, 0);
        // busy for 4 cycles with load_use true, then one load-use stall
        for (int i = 0; i < 4; i++)
            vec(1, 1,1,5'd5,5'd0,5'd5, 0,1, O_BUSY, i, 0);
        vec(1, 1,1,5'd5,5'd0,5'd5, 0,0, O_LU,   4, 0);
        vec(1, 1,1,5'd5,5'd0,5'd5, 0,0, O_RUN,  5, 0);
        vec(1, 0,0,5'd0,5'd0,5'd0, 0,0, O_RUN,  5, 0);
        // branch overrides busy and load_use; FLUSH evaluates load_use normally
        vec(1, 1,1,5'd5,5'd0,5'd5, 1,1, O_BR,   5, 0);
        vec(1, 1,1,5'd5,5'd0,5'd5, 0,0, O_LU,   5, 1);
        vec(1, 0,0,5'd0,5'd0,5'd0, 0,0, O_RUN,  6, 1);
        // branch during LOAD_STALL
        vec(1, 1,1,5'd5,5'd5,5'd0, 0,0, O_LU,   6, 1);
        vec(1, 0,0,5'd0,5'd0,5'd0, 1,0, O_BR,   7, 1);
        vec(1, 0,0,5'd0,5'd0,5'd0, 0,0, O_RUN,  7, 2);
        // back-to-back branches drive flush_count into saturation
        for (int i = 0; i < 14; i++)
            vec(1, 0,0,5'd0,5'd0,5'd0, 1,0, O_BR, 7, (2 + i > 15) ? 15 : 2 + i);
        // long busy drives stall_count into saturation
        for (int i = 0; i < 11; i++)
            vec(1, 0,0,5'd0,5'd0,5'd0, 0,1, O_BUSY, (7 + i > 15) ? 15 : 7 + i, 15);
        // reset mid-BUSY: INIT outputs and zero counters at once
        vec(0, 0,0,5'd0,5'd0,5'd0, 0,1, O_INIT, 0, 0);
        vec(0, 1,1,5'd5,5'd5,5'd5, 1,1, O_INIT, 0, 0);
        vec(1, 0,0,5'd0,5'd0,5'd0, 0,0, O_INIT, 0, 0);
        vec(1, 1,1,5'd0,5'd0,5'd0, 0,0, O_RUN,  0, 0);
        // reset mid-LOAD_STALL and mid-FLUSH
        vec(1, 1,1,5'd9,5'd9,5'd1, 0,0, O_LU,   0, 0);
        vec(0, 0,0,5'd0,5'd0,5'd0, 0,0, O_INIT, 0, 0);
        vec(1, 0,0,5'd0,5'd0,5'd0, 0,0, O_INIT, 0, 0);
        vec(1, 0,0,5'd0,5'd0,5'd0, 1,0, O_BR,   0, 0);
        vec(0, 0,0,5'd0,5'd0,5'd0, 0,0, O_INIT, 0, 0);
        vec(1, 0,0,5'd0,5'd0,5'd0, 0,0, O_INIT, 0, 0);
        vec(1, 0,0,5'd0,5'd0,5'd0, 0,0, O_RUN,  0, 0);
        @(posedge clk);
        @(posedge clk);
        n_checks++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain got=%0d pending exp=0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 Parameter CNT_W, default 32: width of both performance counters.
REQ-002 clk  in  1  clock; all state updates on rising edge.
REQ-003 reset  in  1  one clock; reset is asynchronous and active-low.
REQ-004 ID_rs1, ID_rs2  in  5 each  source registers of the instruction in IF/ID.
REQ-005 ID_valid  in  1  IF/ID holds a real instruction.
REQ-006 EX_MemRead  in  1  instruction in ID/EX is a load.
REQ-007 EX_rd  in  5  destination register of the instruction in ID/EX.
REQ-008 EX_branch_taken  in  1  branch/jump resolved taken in EX this cycle.
REQ-009 EX_busy  in  1  multi-cycle EX unit not done; the whole front end must freeze.
REQ-010 PCWrite  out  1  1 = PC loads PC_In; 0 = PC holds.
REQ-011 IF_ID_Write  out  1  1 = IF/ID register loads; 0 = holds.
REQ-012 ID_EX_Write  out  1  1 = ID/EX register loads; 0 = holds.
REQ-013 ID_EX_Bubble  out  1  zero ID/EX control fields on load (insert NOP).
REQ-014 IF_ID_Flush, ID_EX_Flush  out  1 each  clear the register to NOP on next edge.
REQ-015 stall_count, flush_count  out  CNT_W each  saturating event counters.

Function
REQ-016 FSM states: INIT, RUN, LOAD_STALL, BUSY, FLUSH; state held in a register.
REQ-017 load_use = ID_valid & EX_MemRead & (EX_rd != 0) & (EX_rd == ID_rs1 | EX_rd == ID_rs2), combinational.
REQ-018 Priority, highest first: INIT, EX_branch_taken, EX_busy, load_use, none.
REQ-019 INIT: PCWrite = 0, IF_ID_Write = 0, ID_EX_Write = 1, ID_EX_Bubble = 1, flushes = 0; next state is RUN unconditionally.
REQ-020 Branch cycle (EX_branch_taken = 1 and state != INIT): PCWrite = 1, IF_ID_Flush = 1, ID_EX_Flush = 1, IF_ID_Write = 1, ID_EX_Write = 1; next = FLUSH.
REQ-021 Branch overrides EX_busy and load_use in the same cycle; flush_count increments by 1.
REQ-022 FLUSH lasts exactly one cycle with all outputs as in RUN and no flush asserted; load_use/busy/branch are evaluated normally in that cycle per REQ-018.
REQ-023 Busy cycle (EX_busy = 1, no branch): PCWrite = 0, IF_ID_Write = 0, ID_EX_Write = 0, ID_EX_Bubble = 0; next = BUSY; stall_count increments.
REQ-024 BUSY is held while EX_busy = 1; when it is 0, REQ-018 is evaluated in that cycle; no recovery bubble is inserted.
REQ-025 Load-use cycle (no branch, no busy): PCWrite = 0, IF_ID_Write = 0, ID_EX_Write = 1, ID_EX_Bubble = 1; next = LOAD_STALL; stall_count increments.
REQ-026 LOAD_STALL: load_use is ignored for one cycle (the bubble is now in EX); the outputs are as in RUN unless branch or busy apply.
REQ-027 RUN (no event): PCWrite = 1, IF_ID_Write = 1, ID_EX_Write = 1, Bubble = 0, flushes = 0.
REQ-028 All outputs are combinational functions of state and inputs; there is no added latency.
REQ-029 Counters saturate at all-ones and never wrap; each counter adds at most 1 per cycle.
REQ-030 EX_rd = 0 never causes a stall; ID_valid = 0 suppresses load_use only.

Reset
REQ-031 reset low asynchronously forces state = INIT and stall_count = flush_count = 0.
REQ-032 While reset is low, the outputs equal the INIT values (PCWrite = 0).
REQ-033 After reset rises, the first edge leaves INIT, so PCWrite first becomes 1 in the second post-reset cycle.
REQ-034 Reset asserted mid-BUSY, mid-LOAD_STALL or mid-FLUSH abandons the operation immediately with no residual flush or stall.

Verification
REQ-035 Release reset, no hazards -> PCWrite 0 for one cycle, then 1 continuously; counters stay 0.
REQ-036 EX_MemRead = 1, EX_rd = 5, ID_rs2 = 5, ID_valid = 1 held 2 cycles -> one cycle with PCWrite = 0 and Bubble = 1, then RUN; stall_count = 1.
REQ-037 Same as REQ-036 with EX_rd = 0 -> no stall; stall_count = 0.
REQ-038 EX_busy high 4 cycles with load_use also true -> PCWrite = 0 and ID_EX_Write = 0 for 4 cycles, then one load-use stall; stall_count = 5.
REQ-039 EX_branch_taken with EX_busy = 1 and load_use = 1 -> both flushes = 1 and PCWrite = 1; flush_count = 1; stall_count unchanged.
REQ-040 Preload stall_count to all-ones (force) then trigger a stall -> value unchanged; reset low mid-BUSY -> PCWrite = 0 immediately and counters = 0.
